instruction_queue_decoder: RTL and testbench
============================================

# instruction_queue_decoder

Buffered, handshaked instruction-field decoder sitting between instruction fetch and the register-file/control stage. Accepts 32-bit MIPS instruction words with their PC, queues up to DEPTH entries, and presents the queue head fully split into opcode, rs, rt, rd, shamt, funct, imm16, target26, plus an instruction class and an extended immediate. It generalises the combinational field separator with buffering, backpressure, flush and immediate-extension mode.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- PC_W, 32: PC width carried alongside each instruction
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has an instruction
- in_ready  out  1  queue can accept (not full)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  discard all queued entries (branch/jump redirect)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_pc  out  PC_W  PC of head
- out_instr  out  32  raw head word
- opcode  out  6  [31:26]
- rs, rt, rd  out  5 each  [25:21], [20:16], [15:11]
- shamt  out  5  [10:6]
- funct  out  6  [5:0]
- imm16  out  16  [15:0]
- target  out  26  [25:0]
- iclass  out  2  0=R, 1=I, 2=J, 3=reserved (never produced)
- imm_ext  out  32  extended imm16
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer, write/read pointers $clog2(DEPTH) bits, wrap naturally at DEPTH.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count != DEPTH); out_valid = (count != 0). No pass-through when empty, no push on full even if popping same cycle.
- Simultaneous push and pop (not full, not empty): both occur, count unchanged.
- All field outputs are combinational slices of the head storage entry; they hold stable while out_valid && !out_ready.
- iclass: opcode 0x00 → R; 0x02 or 0x03 → J; all others → I.
- imm_ext: zero-extend for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori); sign-extend otherwise (including R/J, where value is don't-care but must follow this rule).
- flush: pointers and count to 0 at next edge; a push or pop requested in the flush cycle is ignored. Flush has priority over everything except reset.
- When out_valid=0, field outputs are driven from the stale head slot (not required to be zero); benches check them only when out_valid=1.

## Timing
- Reset (async assert, sync-safe deassert at clk): pointers 0, count 0, in_ready 1, out_valid 0; storage not cleared.
- Latency: instruction pushed at edge N is visible with out_valid=1 after edge N (one cycle enqueue-to-head when empty).
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all queued entries lost immediately, outputs go to reset values without waiting for clk.
- After flush edge: out_valid=0, in_ready=1, count=0 in the following cycle.

## Structure
- Shared header: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI) and iclass encodings.
- One sub-module: existing instruction_separator instantiated on the head word for field slicing; class/extension logic local.
- Storage as reg arrays of 32+PC_W bits.

## Test plan
- Reset then push 0x014B4820, pc 0x00400000 → next cycle out_valid=1, opcode 0, rs 10, rt 11, rd 9, shamt 0, funct 0x20, iclass R, count 1.
- Push 0x2108FFFF (addi) → rs 8, rt 8, imm16 0xFFFF, imm_ext 0xFFFFFFFF, iclass I; push 0x3408FFFF (ori) → imm_ext 0x0000FFFF.
- Push 0x08100000 (j) → opcode 2, target 0x0100000, iclass J; 0x0C100000 (jal) → iclass J.
- DEPTH=4, out_ready=0, push 5 words → in_ready falls after 4th, 5th not accepted, count=4; then drain with out_ready=1 → words emerge in order, count 3,2,1,0, pointers wrap correctly on refill.
- Full queue, flush=1 with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, in_ready=1, pushed word dropped.
- Count=2, assert rst_n=0 between edges → out_valid=0, count=0 immediately; after release a push behaves as first test.

Source files
------------

// File: rtl/instruction_queue_decoder_pkg.sv
// Shared opcode constants, instruction-class encoding and decode helpers
// for the instruction queue decoder.
package instruction_queue_decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef enum logic [1:0] {
    ICLASS_R    = 2'd0,
    ICLASS_I    = 2'd1,
    ICLASS_J    = 2'd2,
    ICLASS_RSVD = 2'd3
  } iclass_e;

  function automatic iclass_e classify(input logic [5:0] op);
    if (op == OP_RTYPE)
      return ICLASS_R;
    else if (op == OP_J || op == OP_JAL)
      return ICLASS_J;
    else
      return ICLASS_I;
  endfunction

  // Logical immediates zero-extend; everything else sign-extends.
  function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      return {16'h0000, imm};
    else
      return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instruction_queue_decoder_separator.sv
// Purely combinational MIPS instruction field separator.
module instruction_separator (
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] target
);

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign target = instr[25:0];

endmodule

// File: rtl/instruction_queue_decoder.sv
// Circular instruction queue with handshakes and flush; the head entry is
// presented split into fields with class and extended immediate.
module instruction_queue_decoder
  import instruction_queue_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imm16,
  output logic [25:0]              target,
  output logic [1:0]               iclass,
  output logic [31:0]              imm_ext,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + PC_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_pc, in_instr};
  end

  assign head      = mem[rptr];
  assign out_pc    = head[ENT_W-1:32];
  assign out_instr = head[31:0];

  instruction_separator u_sep (
    .instr  (out_instr),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16),
    .target (target)
  );

  assign iclass  = classify(opcode);
  assign imm_ext = extend_imm(opcode, imm16);

endmodule

// File: tb/tb_instruction_queue_decoder.sv
// Directed bench for instruction_queue_decoder (DEPTH=4, PC_W=32).
module tb_instruction_queue_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [1:0]  iclass;
  logic [31:0] imm_ext;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [31:0] fw [5];

  instruction_queue_decoder #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .target(target), .iclass(iclass), .imm_ext(imm_ext), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    fw[0] = 32'h11111111; fw[1] = 32'h22222222; fw[2] = 32'h33333333;
    fw[3] = 32'h44444444; fw[4] = 32'h55555555;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    rst_n = 1'b1;
    step();

    // R-type push, one-cycle latency
    in_valid = 1'b1; in_instr = 32'h014B4820; in_pc = 32'h00400000;
    step();
    in_valid = 1'b0;
    check("r_out_valid", 64'(out_valid), 64'd1);
    check("r_opcode", 64'(opcode), 64'd0);
    check("r_rs",     64'(rs),     64'd10);
    check("r_rt",     64'(rt),     64'd11);
    check("r_rd",     64'(rd),     64'd9);
    check("r_shamt",  64'(shamt),  64'd0);
    check("r_funct",  64'(funct),  64'h20);
    check("r_iclass", 64'(iclass), 64'd0);
    check("r_count",  64'(count),  64'd1);
    check("r_pc",     64'(out_pc), 64'h00400000);

    // Simultaneous push/pop: addi replaces add at head
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h2108FFFF; in_pc = 32'h00400004;
    step();
    check("addi_count",   64'(count),   64'd1);
    check("addi_rs",      64'(rs),      64'd8);
    check("addi_rt",      64'(rt),      64'd8);
    check("addi_imm16",   64'(imm16),   64'hFFFF);
    check("addi_imm_ext", 64'(imm_ext), 64'hFFFFFFFF);
    check("addi_iclass",  64'(iclass),  64'd1);
    check("addi_pc",      64'(out_pc),  64'h00400004);

    in_instr = 32'h3408FFFF; in_pc = 32'h00400008;
    step();
    check("ori_imm_ext", 64'(imm_ext), 64'h0000FFFF);
    check("ori_iclass",  64'(iclass),  64'd1);

    in_instr = 32'h08100000; in_pc = 32'h0040000C;
    step();
    check("j_opcode", 64'(opcode), 64'd2);
    check("j_target", 64'(target), 64'h0100000);
    check("j_iclass", 64'(iclass), 64'd2);

    in_instr = 32'h0C100000; in_pc = 32'h00400010;
    step();
    check("jal_opcode", 64'(opcode), 64'd3);
    check("jal_iclass", 64'(iclass), 64'd2);

    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("drain_count",     64'(count),     64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Fill past full with pointers starting mid-buffer
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = fw[i]; in_pc = 32'h1000 + 32'(4 * i);
      step();
      check($sformatf("fill_count_%0d", i), 64'(count), 64'(i < 4 ? i + 1 : 4));
      check($sformatf("fill_in_ready_%0d", i), 64'(in_ready), 64'(i < 3 ? 1 : 0));
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_instr_%0d", i), 64'(out_instr), 64'(fw[i]));
      check($sformatf("drain_pc_%0d", i),    64'(out_pc),    64'(32'h1000 + 32'(4 * i)));
      step();
      check($sformatf("drain_cnt_%0d", i),   64'(count),     64'(3 - i));
    end
    out_ready = 1'b0;
    check("empty_out_valid", 64'(out_valid), 64'd0);

    // Refill after wrap, order preserved
    in_valid = 1'b1; in_instr = 32'hAAAA0001; in_pc = 32'h2000; step();
    in_instr = 32'hBBBB0002; in_pc = 32'h2004; step();
    in_valid = 1'b0;
    check("refill_count", 64'(count),     64'd2);
    check("refill_head0", 64'(out_instr), 64'hAAAA0001);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("refill_head1", 64'(out_instr), 64'hBBBB0002);
    check("refill_pc1",   64'(out_pc),    64'h2004);

    // Fill to full, then flush with push and pop requested
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = fw[i]; step();
    end
    in_valid = 1'b0;
    check("preflush_count", 64'(count), 64'd4);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hDEAD0000;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count",     64'(count),     64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b1; in_instr = 32'hCAFE0001; in_pc = 32'h3000; step();
    in_valid = 1'b0;
    check("postflush_count", 64'(count),     64'd1);
    check("postflush_head",  64'(out_instr), 64'hCAFE0001);

    // Asynchronous reset mid-operation
    in_valid = 1'b1; in_instr = 32'hCAFE0002; step();
    in_valid = 1'b0;
    check("prerst_count", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count",     64'(count),     64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_instr = 32'h014B4820; in_pc = 32'h00400000;
    step();
    in_valid = 1'b0;
    check("rr_out_valid", 64'(out_valid), 64'd1);
    check("rr_count",     64'(count),     64'd1);
    check("rr_rd",        64'(rd),        64'd9);
    check("rr_funct",     64'(funct),     64'h20);
    check("rr_pc",        64'(out_pc),    64'h00400000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
